// File: rtl/game_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : game_sequencer
//  Purpose  : Pong game controller. Steps the play field through menu, serve,
//             rally, point pause and game over. Keeps both scores and detects
//             the win against a target score chosen in the menu.
//  Revision : 1.0 - initial release
// ============================================================================
module game_sequencer #(
   parameter int WIN_A        = 5,
   parameter int WIN_B        = 11,
   parameter int POINT_FRAMES = 60
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       frame_tick,
   input  logic       btn_launch,
   input  logic       btn_up,
   input  logic       btn_down,
   input  logic       left_hit,
   input  logic       right_hit,
   output logic [2:0] state,
   output logic       menu_sel,
   output logic       ball_reset,
   output logic       play_en,
   output logic       serve_side,
   output logic [4:0] score_p1,
   output logic [4:0] score_p2,
   output logic       game_over,
   output logic       winner
);

   // The pause counter only has to reach POINT_FRAMES-1.
   localparam int            c_cnt_w   = (POINT_FRAMES > 1) ? $clog2(POINT_FRAMES) : 1;
   localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(POINT_FRAMES - 1);
   localparam logic [4:0]    c_win_a   = 5'(WIN_A);
   localparam logic [4:0]    c_win_b   = 5'(WIN_B);
   localparam logic [4:0]    c_max     = 5'd31;

   typedef enum logic [2:0] {
      ST_MENU  = 3'd0,
      ST_START = 3'd2,
      ST_PLAY  = 3'd3,
      ST_POINT = 3'd4,
      ST_OVER  = 3'd5
   } state_t;

   state_t               r_state;
   logic                 r_menu_sel;
   logic                 r_serve_side;
   logic [4:0]           r_score_p1;
   logic [4:0]           r_score_p2;
   logic                 r_winner;
   logic [4:0]           r_target;
   logic [c_cnt_w-1:0]   r_frame_cnt;

   // Button bit order: [0] launch, [1] up, [2] down
   logic [2:0]           r_sync1;
   logic [2:0]           r_sync2;
   logic [2:0]           r_prev;
   logic [2:0]           w_press;
   logic                 w_launch;
   logic                 w_up;
   logic                 w_down;

   // Two-flop synchronizer plus previous-value flop for rising-edge detection
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_sync1 <= 3'b000;
         r_sync2 <= 3'b000;
         r_prev  <= 3'b000;
      end else begin
         r_sync1 <= {btn_down, btn_up, btn_launch};
         r_sync2 <= r_sync1;
         r_prev  <= r_sync2;
      end
   end

   assign w_press  = r_sync2 & ~r_prev;
   assign w_launch = w_press[0];
   assign w_up     = w_press[1];
   assign w_down   = w_press[2];

   // Game state machine with registered score, serve, menu and winner outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state      <= ST_MENU;
         r_menu_sel   <= 1'b0;
         r_serve_side <= 1'b0;
         r_score_p1   <= 5'd0;
         r_score_p2   <= 5'd0;
         r_winner     <= 1'b0;
         r_target     <= c_win_a;
         r_frame_cnt  <= '0;
      end else begin
         case (r_state)
            ST_MENU: begin
               // Simultaneous up and down presses cancel out
               if (w_up && !w_down) begin
                  r_menu_sel <= 1'b0;
               end else if (w_down && !w_up) begin
                  r_menu_sel <= 1'b1;
               end
               if (w_launch) begin
                  r_target     <= r_menu_sel ? c_win_b : c_win_a;
                  r_score_p1   <= 5'd0;
                  r_score_p2   <= 5'd0;
                  r_serve_side <= 1'b0;
                  r_state      <= ST_START;
               end
            end
            ST_START: begin
               if (w_launch) begin
                  r_state <= ST_PLAY;
               end
            end
            ST_PLAY: begin
               // Left wall wins a tie so a double hit never scores twice
               if (left_hit) begin
                  if (r_score_p2 != c_max) begin
                     r_score_p2 <= r_score_p2 + 5'd1;
                  end
                  r_serve_side <= 1'b0;
                  r_frame_cnt  <= '0;
                  r_state      <= ST_POINT;
               end else if (right_hit) begin
                  if (r_score_p1 != c_max) begin
                     r_score_p1 <= r_score_p1 + 5'd1;
                  end
                  r_serve_side <= 1'b1;
                  r_frame_cnt  <= '0;
                  r_state      <= ST_POINT;
               end
            end
            ST_POINT: begin
               if (frame_tick) begin
                  if (r_frame_cnt == c_last) begin
                     if ((r_score_p1 >= r_target) || (r_score_p2 >= r_target)) begin
                        r_winner <= (r_score_p2 >= r_target);
                        r_state  <= ST_OVER;
                     end else begin
                        r_state  <= ST_START;
                     end
                  end else begin
                     r_frame_cnt <= r_frame_cnt + c_cnt_w'(1);
                  end
               end
            end
            ST_OVER: begin
               if (w_launch) begin
                  r_state <= ST_MENU;
               end
            end
            default: begin
               r_state <= ST_MENU;
            end
         endcase
      end
   end

   assign state      = r_state;
   assign menu_sel   = r_menu_sel;
   assign serve_side = r_serve_side;
   assign score_p1   = r_score_p1;
   assign score_p2   = r_score_p2;
   assign winner     = r_winner;

   // Phase strobes come straight off the state register
   assign ball_reset = (r_state == ST_START);
   assign play_en    = (r_state == ST_PLAY);
   assign game_over  = (r_state == ST_OVER);

endmodule
`default_nettype wire

// File: tb/tb_game_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_game_sequencer
//  Purpose  : Self-checking bench for game_sequencer. Expected status words
//             are queued as stimulus is applied and compared once the DUT
//             has had time to respond.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_game_sequencer;

   localparam int POINT_FRAMES = 60;
   localparam logic [2:0] S_MENU  = 3'd0;
   localparam logic [2:0] S_START = 3'd2;
   localparam logic [2:0] S_PLAY  = 3'd3;
   localparam logic [2:0] S_PT    = 3'd4;
   localparam logic [2:0] S_GO    = 3'd5;

   logic       clk        = 1'b0;
   logic       reset      = 1'b1;
   logic       frame_tick = 1'b0;
   logic       btn_launch = 1'b0;
   logic       btn_up     = 1'b0;
   logic       btn_down   = 1'b0;
   logic       left_hit   = 1'b0;
   logic       right_hit  = 1'b0;
   logic [2:0] state;
   logic       menu_sel;
   logic       ball_reset;
   logic       play_en;
   logic       serve_side;
   logic [4:0] score_p1;
   logic [4:0] score_p2;
   logic       game_over;
   logic       winner;

   int n_err = 0;
   int n_chk = 0;

   // Scoreboard of pending expectations
   string       tag_q[$];
   logic [18:0] exp_q[$];

   // Reference model of the visible game status
   int e_p1    = 0;
   int e_p2    = 0;
   bit e_serve = 1'b0;
   bit e_msel  = 1'b0;
   bit e_win   = 1'b0;

   game_sequencer #(
      .WIN_A        (5),
      .WIN_B        (11),
      .POINT_FRAMES (POINT_FRAMES)
   ) u_dut (
      .clk        (clk),
      .reset      (reset),
      .frame_tick (frame_tick),
      .btn_launch (btn_launch),
      .btn_up     (btn_up),
      .btn_down   (btn_down),
      .left_hit   (left_hit),
      .right_hit  (right_hit),
      .state      (state),
      .menu_sel   (menu_sel),
      .ball_reset (ball_reset),
      .play_en    (play_en),
      .serve_side (serve_side),
      .score_p1   (score_p1),
      .score_p2   (score_p2),
      .game_over  (game_over),
      .winner     (winner)
   );

   always #5 clk = ~clk;

   // Watchdog so the run can never hang
   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [18:0] mk(input logic [2:0] s);
      return {s, e_msel, (s == S_START), (s == S_PLAY), e_serve,
              5'(e_p1), 5'(e_p2), (s == S_GO), e_win};
   endfunction

   function automatic logic [18:0] obs();
      return {state, menu_sel, ball_reset, play_en, serve_side,
              score_p1, score_p2, game_over, winner};
   endfunction

   task automatic chk(input string tag, input logic [18:0] got, input logic [18:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got st=%0d sel=%0b br=%0b pe=%0b srv=%0b p1=%0d p2=%0d go=%0b win=%0b, expected st=%0d sel=%0b br=%0b pe=%0b srv=%0b p1=%0d p2=%0d go=%0b win=%0b",
                  tag, got[18:16], got[15], got[14], got[13], got[12], got[11:7], got[6:2], got[1], got[0],
                  exp[18:16], exp[15], exp[14], exp[13], exp[12], exp[11:7], exp[6:2], exp[1], exp[0]);
      end
   endtask

   task automatic push(input string tag, input logic [2:0] s);
      tag_q.push_back(tag);
      exp_q.push_back(mk(s));
   endtask

   task automatic settle();
      while (exp_q.size() > 0) begin
         chk(tag_q.pop_front(), obs(), exp_q.pop_front());
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drive_btn(input int b, input logic v);
      case (b)
         0: btn_launch = v;
         1: btn_up     = v;
         2: btn_down   = v;
         default: begin btn_up = v; btn_down = v; end
      endcase
   endtask

   // One-clk button press; result visible after the third edge
   task automatic press(input int b, input string tag, input logic [2:0] s_exp);
      push(tag, s_exp);
      drive_btn(b, 1'b1);
      tick(1);
      drive_btn(b, 1'b0);
      tick(2);
      settle();
   endtask

   // side: 0 right wall, 1 left wall, 2 both
   task automatic hit(input int side, input string tag, input logic [2:0] s_exp);
      push(tag, s_exp);
      right_hit = (side != 1);
      left_hit  = (side != 0);
      tick(1);
      right_hit = 1'b0;
      left_hit  = 1'b0;
      settle();
   endtask

   task automatic frames(input int n, input string tag, input logic [2:0] s_exp);
      push(tag, s_exp);
      for (int i = 0; i < n; i++) begin
         frame_tick = 1'b1;
         tick(1);
         frame_tick = 1'b0;
         tick(1);
      end
      settle();
   endtask

   // Serve, score one point, sit out the pause
   task automatic point(input bit p2, input logic [2:0] end_s);
      press(0, "serve", S_PLAY);
      if (p2) begin
         e_p2++;
         e_serve = 1'b0;
         hit(1, "hit_p2", S_PT);
      end else begin
         e_p1++;
         e_serve = 1'b1;
         hit(0, "hit_p1", S_PT);
      end
      frames(POINT_FRAMES, "pause_end", end_s);
   endtask

   initial begin
      tick(2);
      reset = 1'b0;
      push("reset", S_MENU);
      settle();

      // Menu navigation
      e_msel = 1'b1; press(2, "menu_down", S_MENU);
      press(3, "menu_both", S_MENU);
      e_msel = 1'b0; press(1, "menu_up", S_MENU);
      e_msel = 1'b1; press(2, "menu_down2", S_MENU);
      press(0, "launch_start", S_START);

      // Launch latency into PLAY: not yet after edge 2, done after edge 3
      btn_launch = 1'b1;
      tick(1);
      btn_launch = 1'b0;
      push("launch_lat2", S_START);
      tick(1);
      settle();
      push("launch_lat3", S_PLAY);
      tick(1);
      settle();

      // Right wall hit, then inputs ignored during the pause
      e_p1 = 1; e_serve = 1'b1;
      hit(0, "right_hit", S_PT);
      press(0, "pt_launch_ign", S_PT);
      hit(1, "pt_hit_ign", S_PT);
      frames(POINT_FRAMES - 1, "pause_59", S_PT);
      frames(1, "pause_60", S_START);
      hit(0, "start_hit_ign", S_START);

      // Double hit counts as left wall only
      press(0, "serve_dbl", S_PLAY);
      e_p2 = 1; e_serve = 1'b0;
      hit(2, "both_hits", S_PT);
      frames(POINT_FRAMES, "pause_dbl", S_START);

      // Build 3:2 against target 11 and reset asynchronously mid-rally
      point(1'b0, S_START);
      point(1'b0, S_START);
      point(1'b1, S_START);
      press(0, "serve_32", S_PLAY);
      #2;
      reset = 1'b1;
      #1;
      e_p1 = 0; e_p2 = 0; e_serve = 1'b0; e_msel = 1'b0; e_win = 1'b0;
      push("async_reset", S_MENU);
      settle();
      tick(1);
      reset = 1'b0;

      // Game to 5 (menu option 0), finishing 5:4
      press(0, "launch_g2", S_START);
      for (int i = 0; i < 4; i++) begin
         point(1'b0, S_START);
         point(1'b1, S_START);
      end
      e_win = 1'b0;
      point(1'b0, S_GO);
      press(0, "over_menu", S_MENU);

      // Held launch gives exactly one transition
      e_p1 = 0; e_p2 = 0; e_serve = 1'b0;
      push("hold_start", S_START);
      btn_launch = 1'b1;
      tick(3);
      settle();
      push("hold_100", S_START);
      tick(97);
      btn_launch = 1'b0;
      tick(3);
      settle();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/game_sequencer.md
# game_sequencer

Top-level game controller for the pong design. It sequences the play field through menu, serve, rally, point-pause and game-over phases, and keeps both players' scores. It detects the win condition from a target score selected in the menu. It sits between the button inputs and the ball/paddle animation logic, and drives the state and score values consumed by the drawing and 7-segment score paths.

## Interface
Parameters:
- WIN_A, default 5: target score when menu option 0 is selected; must be 1..31.
- WIN_B, default 11: target score when menu option 1 is selected; must be 1..31.
- POINT_FRAMES, default 60: number of frame_tick pulses spent in END_POINT; must be ≥1.

Ports:
- clk, input, 1: system clock; every register uses this clock.
- reset, input, 1: asynchronous, active-high reset.
- frame_tick, input, 1: one-clk pulse per video frame (asserted at y==480, x==0).
- btn_launch, input, 1: raw launch button level; debounced upstream.
- btn_up, input, 1: raw menu-up button level; debounced upstream.
- btn_down, input, 1: raw menu-down button level; debounced upstream.
- left_hit, input, 1: ball reached the left wall; player 2 scores.
- right_hit, input, 1: ball reached the right wall; player 1 scores.
- state, output, 3: current state. MENU=0, START=2, PLAY=3, END_POINT=4, END_GAME=5.
- menu_sel, output, 1: highlighted menu option (0 = WIN_A, 1 = WIN_B).
- ball_reset, output, 1: high while state==START; ball and paddles are held at their serve positions.
- play_en, output, 1: high while state==PLAY; enables ball and paddle motion.
- serve_side, output, 1: side that serves next (0 = left/P1, 1 = right/P2).
- score_p1, output, 5: player 1 score.
- score_p2, output, 5: player 2 score.
- game_over, output, 1: high while state==END_GAME.
- winner, output, 1: 0 = P1, 1 = P2; valid while game_over is high.

## Operation
- Button conditioning:
  - Each button goes through a 2-flop synchronizer followed by a previous-value flop.
  - The press pulse is `sync & ~prev`, so one held press produces exactly one pulse.
- MENU:
  - up-press clears menu_sel to 0; down-press sets menu_sel to 1.
  - If up and down pulse in the same cycle, menu_sel is unchanged.
  - launch-press:
    - Latches the target (WIN_A or WIN_B per menu_sel).
    - Clears both scores, clears serve_side, and moves to START.
- START: launch-press moves to PLAY. Hit inputs are ignored.
- PLAY: hits are sampled only in this state.
  - right_hit: score_p1 increments, serve_side becomes 1, move to END_POINT.
  - left_hit: score_p2 increments, serve_side becomes 0, move to END_POINT.
  - Both hits in the same cycle: treated as left_hit only.
- END_POINT:
  - A frame counter clears on entry and increments on each frame_tick.
  - When it reaches POINT_FRAMES:
    - If either score ≥ the latched target: set winner (1 if score_p2 is at or above target, else 0) and move to END_GAME.
    - Otherwise move to START.
  - Buttons and hits are ignored in this state.
- END_GAME: scores are held; launch-press moves to MENU. menu_sel keeps its last value.
- Scores saturate at 31; the target is always ≤31, so wrap-around cannot occur.
- Unused encodings (1, 6, 7) return to MENU on the next clk.

## Timing
- Reset values:
  - state=MENU; menu_sel=0; serve_side=0.
  - score_p1=0; score_p2=0; winner=0.
  - Frame counter, synchronizers and the latched target (WIN_A) all reset.
  - As a consequence, ball_reset=0, play_en=0 and game_over=0.
- Reset mid-game returns to MENU immediately (asynchronously) and clears the scores.
- ball_reset, play_en and game_over are decoded directly from the state register: no added latency, glitch-free.
- Button latency: raw button high is sampled at edge 1; the state or menu_sel change is visible after edge 3.
- Hit latency: a hit that is high at edge N in PLAY updates state, score and serve_side together after edge N. A one-clk hit pulse is sufficient.
- END_POINT ends on the clk edge that samples the POINT_FRAMES-th frame_tick after entry. A frame_tick in the same cycle as entry is not counted.
- The END_POINT → END_GAME/START decision and the winner update happen on the same edge.

## Test plan
- Reset mid-PLAY with score 3:2 → state=0, scores 0:0, play_en=0, immediately, with no clk edge needed.
- MENU: press down, then launch → menu_sel=1, target 11, state=2; a second launch → state=3 and play_en=1 three clks after the press.
- PLAY: 1-clk right_hit → score_p1 +1, serve_side=1, state=4; after 60 frame_ticks → state=2 with ball_reset=1.
- left_hit and right_hit in the same cycle with score 0:0 → score 0:1, serve_side=0; a hit pulse during START or END_POINT → scores unchanged.
- WIN_A=5 selected, score reaches 5:4 → after the pause: state=5, game_over=1, winner=0; launch → state=0 with scores still 5:4 until the next game is launched.
- Hold btn_launch high for 100 clks in MENU → exactly one transition, to START, and no further transition to PLAY.
